// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: D/E/M/W register fields in, stall and forwarding selects out.
interface hazard_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] Tuse_rs_D;
  logic [1:0] Tuse_rt_D;
  logic       md_D;
  logic [4:0] rs_E;
  logic [4:0] rt_E;
  logic [4:0] rt_M;
  logic [4:0] A3_E;
  logic [4:0] A3_M;
  logic [4:0] A3_W;
  logic [3:0] Tnew_E;
  logic [3:0] Tnew_M;
  logic [3:0] Tnew_W;
  logic       md_start_E;
  logic       md_type_E;

  logic        stall;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic        fwd_rt_M;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, md_D, rs_E, rt_E, rt_M,
           A3_E, A3_M, A3_W, Tnew_E, Tnew_M, Tnew_W, md_start_E, md_type_E,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M,
           md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, md_D, rs_E, rt_E, rt_M,
           A3_E, A3_M, A3_W, Tnew_E, Tnew_M, Tnew_W, md_start_E, md_type_E,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M,
           md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: data/MDU stall, forwarding selects,
// multiply/divide busy sequencing and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLen = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLen  = CntW'(DIV_CYCLES);

  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_stall_cnt;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_md_busy;

  assign w_md_busy = (r_cnt != '0);

  // Widen Tuse to Tnew's width so the compare is unsigned and width-matched.
  assign w_stall_rs = (bus.rs_D != 5'd0) &&
                      (((bus.rs_D == bus.A3_E) && (bus.Tnew_E > {2'b00, bus.Tuse_rs_D})) ||
                       ((bus.rs_D == bus.A3_M) && (bus.Tnew_M > {2'b00, bus.Tuse_rs_D})));
  assign w_stall_rt = (bus.rt_D != 5'd0) &&
                      (((bus.rt_D == bus.A3_E) && (bus.Tnew_E > {2'b00, bus.Tuse_rt_D})) ||
                       ((bus.rt_D == bus.A3_M) && (bus.Tnew_M > {2'b00, bus.Tuse_rt_D})));
  assign w_stall_md = bus.md_D && (w_md_busy || bus.md_start_E);
  assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

  always_comb begin
    bus.fwd_rs_D = 2'd0;
    if (bus.rs_D != 5'd0) begin
      if ((bus.A3_E == bus.rs_D) && (bus.Tnew_E == 4'd0))      bus.fwd_rs_D = 2'd3;
      else if ((bus.A3_M == bus.rs_D) && (bus.Tnew_M == 4'd0)) bus.fwd_rs_D = 2'd2;
      else if ((bus.A3_W == bus.rs_D) && (bus.Tnew_W == 4'd0)) bus.fwd_rs_D = 2'd1;
    end

    bus.fwd_rt_D = 2'd0;
    if (bus.rt_D != 5'd0) begin
      if ((bus.A3_E == bus.rt_D) && (bus.Tnew_E == 4'd0))      bus.fwd_rt_D = 2'd3;
      else if ((bus.A3_M == bus.rt_D) && (bus.Tnew_M == 4'd0)) bus.fwd_rt_D = 2'd2;
      else if ((bus.A3_W == bus.rt_D) && (bus.Tnew_W == 4'd0)) bus.fwd_rt_D = 2'd1;
    end

    bus.fwd_rs_E = 2'd0;
    if (bus.rs_E != 5'd0) begin
      if ((bus.A3_M == bus.rs_E) && (bus.Tnew_M == 4'd0))      bus.fwd_rs_E = 2'd2;
      else if ((bus.A3_W == bus.rs_E) && (bus.Tnew_W == 4'd0)) bus.fwd_rs_E = 2'd1;
    end

    bus.fwd_rt_E = 2'd0;
    if (bus.rt_E != 5'd0) begin
      if ((bus.A3_M == bus.rt_E) && (bus.Tnew_M == 4'd0))      bus.fwd_rt_E = 2'd2;
      else if ((bus.A3_W == bus.rt_E) && (bus.Tnew_W == 4'd0)) bus.fwd_rt_E = 2'd1;
    end

    bus.fwd_rt_M = (bus.rt_M != 5'd0) && (bus.A3_W == bus.rt_M) && (bus.Tnew_W == 4'd0);
  end

  // A start while busy simply reloads; the MDU stall keeps that out of normal flow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (bus.md_start_E) begin
      r_cnt <= bus.md_type_E ? DivLen : MultLen;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall     = w_stall;
  assign bus.md_busy   = w_md_busy;
  assign bus.md_done   = (r_cnt == CntW'(1));
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall rules, forwarding priority, MDU timing, stall counter.
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int   errs;
  int   checks;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rs_D = 5'd0; bus.rt_D = 5'd0; bus.Tuse_rs_D = 2'd3; bus.Tuse_rt_D = 2'd3;
    bus.md_D = 1'b0; bus.rs_E = 5'd0; bus.rt_E = 5'd0; bus.rt_M = 5'd0;
    bus.A3_E = 5'd0; bus.A3_M = 5'd0; bus.A3_W = 5'd0;
    bus.Tnew_E = 4'd0; bus.Tnew_M = 4'd0; bus.Tnew_W = 4'd0;
    bus.md_start_E = 1'b0; bus.md_type_E = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    bus.md_start_E = 1'b1;
    bus.md_type_E  = 1'b1;
    @(negedge clk);
    bus.md_start_E = 1'b0;
    #1;
    checks++;
    if (bus.md_busy !== 1'b0) begin
      errs++; $display("FAIL reset_busy: got %b want 0", bus.md_busy);
    end
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      errs++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_rs_D !== 2'd0) begin
      errs++; $display("FAIL reset_comb: got stall=%b fwd=%0d want 0/0", bus.stall, bus.fwd_rs_D);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) begin
      errs++; $display("FAIL reset_release: got busy=%b done=%b want 0/0", bus.md_busy, bus.md_done);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    bus.A3_E = 5'd8; bus.Tnew_E = 4'd2; bus.rs_D = 5'd8; bus.Tuse_rs_D = 2'd1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errs++; $display("FAIL lw_in_E_stall: got %b want 1", bus.stall);
    end
    @(negedge clk);
    bus.A3_E = 5'd0; bus.Tnew_E = 4'd0; bus.A3_M = 5'd8; bus.Tnew_M = 4'd1;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_rs_D !== 2'd0) begin
      errs++; $display("FAIL lw_in_M: got stall=%b fwd=%0d want 0/0", bus.stall, bus.fwd_rs_D);
    end
    @(negedge clk);
    bus.A3_M = 5'd0; bus.Tnew_M = 4'd0; bus.A3_W = 5'd8; bus.Tnew_W = 4'd0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_rs_D !== 2'd1) begin
      errs++; $display("FAIL lw_in_W: got stall=%b fwd=%0d want 0/1", bus.stall, bus.fwd_rs_D);
    end
    // rt stall from M; then Tuse=3 and register 0 never stall
    @(negedge clk);
    idle();
    bus.rt_D = 5'd7; bus.Tuse_rt_D = 2'd1; bus.A3_M = 5'd7; bus.Tnew_M = 4'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errs++; $display("FAIL rt_stall_M: got %b want 1", bus.stall);
    end
    bus.Tuse_rt_D = 2'd3; bus.A3_E = 5'd7; bus.Tnew_E = 4'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errs++; $display("FAIL tuse3_no_stall: got %b want 0", bus.stall);
    end
    idle();
    bus.rs_D = 5'd0; bus.Tuse_rs_D = 2'd0; bus.A3_E = 5'd0; bus.Tnew_E = 4'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errs++; $display("FAIL r0_no_stall: got %b want 0", bus.stall);
    end
    idle();
    bus.rs_D = 5'd4; bus.Tuse_rs_D = 2'd0; bus.A3_W = 5'd4; bus.Tnew_W = 4'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errs++; $display("FAIL w_no_stall: got %b want 0", bus.stall);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    idle();
    bus.A3_E = 5'd9; bus.A3_M = 5'd9; bus.rs_D = 5'd9; bus.rt_D = 5'd9;
    #1;
    checks++;
    if (bus.fwd_rs_D !== 2'd3 || bus.fwd_rt_D !== 2'd3) begin
      errs++; $display("FAIL fwd_D_E_wins: got rs=%0d rt=%0d want 3/3", bus.fwd_rs_D, bus.fwd_rt_D);
    end
    bus.A3_E = 5'd0;
    #1;
    checks++;
    if (bus.fwd_rs_D !== 2'd2 || bus.fwd_rt_D !== 2'd2) begin
      errs++; $display("FAIL fwd_D_M: got rs=%0d rt=%0d want 2/2", bus.fwd_rs_D, bus.fwd_rt_D);
    end
    idle();
    #1;
    checks++;
    if (bus.fwd_rs_D !== 2'd0 || bus.stall !== 1'b0) begin
      errs++; $display("FAIL fwd_D_r0: got fwd=%0d stall=%b want 0/0", bus.fwd_rs_D, bus.stall);
    end
    bus.rt_E = 5'd5; bus.rs_E = 5'd5; bus.A3_M = 5'd5; bus.A3_W = 5'd5;
    #1;
    checks++;
    if (bus.fwd_rt_E !== 2'd2 || bus.fwd_rs_E !== 2'd2) begin
      errs++; $display("FAIL fwd_E_M: got rt=%0d rs=%0d want 2/2", bus.fwd_rt_E, bus.fwd_rs_E);
    end
    bus.Tnew_M = 4'd1;
    #1;
    checks++;
    if (bus.fwd_rt_E !== 2'd1 || bus.fwd_rs_E !== 2'd1) begin
      errs++; $display("FAIL fwd_E_W: got rt=%0d rs=%0d want 1/1", bus.fwd_rt_E, bus.fwd_rs_E);
    end
    bus.rt_M = 5'd5;
    #1;
    checks++;
    if (bus.fwd_rt_M !== 1'b1) begin
      errs++; $display("FAIL fwd_M_W: got %b want 1", bus.fwd_rt_M);
    end
    bus.Tnew_W = 4'd1;
    #1;
    checks++;
    if (bus.fwd_rt_M !== 1'b0 || bus.fwd_rt_E !== 2'd0) begin
      errs++; $display("FAIL fwd_tnew_nz: got M=%b E=%0d want 0/0", bus.fwd_rt_M, bus.fwd_rt_E);
    end
  endtask

  task automatic test_mult();
    do_reset();
    @(negedge clk);
    idle();
    bus.md_D = 1'b1; bus.md_start_E = 1'b1; bus.md_type_E = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.md_busy !== 1'b0) begin
      errs++; $display("FAIL mult_k: got stall=%b busy=%b want 1/0", bus.stall, bus.md_busy);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.md_start_E = 1'b0;
      #1;
      checks++;
      if (bus.md_busy !== 1'b1 || bus.md_done !== (i == 5) || bus.stall !== 1'b1) begin
        errs++;
        $display("FAIL mult_busy k+%0d: got busy=%b done=%b stall=%b want 1/%b/1",
                 i, bus.md_busy, bus.md_done, bus.stall, (i == 5));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.md_done !== 1'b0 || bus.stall !== 1'b0) begin
      errs++;
      $display("FAIL mult_end: got busy=%b done=%b stall=%b want 0/0/0",
               bus.md_busy, bus.md_done, bus.stall);
    end
  endtask

  task automatic test_div_abort();
    do_reset();
    @(negedge clk);
    idle();
    bus.md_start_E = 1'b1; bus.md_type_E = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.md_start_E = 1'b0;
      #1;
      checks++;
      if (bus.md_busy !== 1'b1 || bus.md_done !== 1'b0) begin
        errs++; $display("FAIL div_busy k+%0d: got busy=%b done=%b want 1/0", i, bus.md_busy, bus.md_done);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.stall_cnt !== 32'd0) begin
      errs++; $display("FAIL div_abort: got busy=%b cnt=%0d want 0/0", bus.md_busy, bus.stall_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b0) begin
        errs++; $display("FAIL div_no_done %0d: got done=%b busy=%b want 0/0", i, bus.md_done, bus.md_busy);
      end
    end
  endtask

  task automatic test_stall_cnt();
    do_reset();
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      errs++; $display("FAIL stall_cnt_zero: got %0d want 0", bus.stall_cnt);
    end
    @(negedge clk);
    bus.rs_D = 5'd8; bus.Tuse_rs_D = 2'd0; bus.A3_E = 5'd8; bus.Tnew_E = 4'd2;
    repeat (3) @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd3) begin
      errs++; $display("FAIL stall_cnt_3: got %0d want 3", bus.stall_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd3) begin
      errs++; $display("FAIL stall_cnt_hold: got %0d want 3", bus.stall_cnt);
    end
    bus.rs_D = 5'd8; bus.Tuse_rs_D = 2'd0; bus.A3_E = 5'd8; bus.Tnew_E = 4'd2;
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL stall_cnt_max: got %h want ffffffff", bus.stall_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL stall_cnt_sat: got %h want ffffffff", bus.stall_cnt);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    reset  = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mult();
    test_div_abort();
    test_stall_cnt();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard controller for the five-stage pipeline. It compares the source registers of the D-stage instruction against the destination register and remaining-latency (Tnew) values carried by the E/M/W pipeline registers, and from that it produces the pipeline stall and the forwarding-mux selects. It also owns the busy counter that sequences the multi-cycle multiply/divide unit and stalls HI/LO-dependent instructions. Its outputs drive the PC/D-register enables, the E-register bubble, and the forwarding muxes in D, E and M.

## Interface
- MULT_CYCLES, 5, cycles a mult/multu occupies the MDU (≥1)
- DIV_CYCLES, 10, cycles a div/divu occupies the MDU (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets)
- rs_D, rt_D  in  5  D-stage source register numbers
- Tuse_rs_D, Tuse_rt_D  in  2  cycles until D instr needs operand; 3 = operand unused
- md_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- rs_E, rt_E, rt_M  in  5  source registers held in the E and M stages
- A3_E, A3_M, A3_W  in  5  destination register per stage; 0 = no write
- Tnew_E, Tnew_M, Tnew_W  in  4  remaining cycles before the result exists
- md_start_E  in  1  E holds a valid mult/div this cycle
- md_type_E  in  1  0 = mult, 1 = div
- stall  out  1  freeze PC and D register, insert bubble into E
- fwd_rs_D, fwd_rt_D  out  2  0 = RF, 1 = W, 2 = M, 3 = E
- fwd_rs_E, fwd_rt_E  out  2  0 = register value, 1 = W, 2 = M
- fwd_rt_M  out  1  0 = register value, 1 = W
- md_busy  out  1  MDU occupied
- md_done  out  1  last busy cycle; HI/LO are written at the end of this cycle
- stall_cnt  out  32  saturating count of stalled cycles

## Operation
- Data stall on rs: rs_D≠0 and ((rs_D==A3_E and Tnew_E>Tuse_rs_D) or (rs_D==A3_M and Tnew_M>Tuse_rs_D)). The rt rule is identical, using rt_D and Tuse_rt_D.
- A Tuse value of 3 never causes a stall, because Tnew is always ≤2 in E.
- W never stalls; Tnew_W is ignored for stall.
- MDU stall: md_D and (md_busy or md_start_E).
- stall is the OR of the rs data stall, the rt data stall and the MDU stall. It is purely combinational.
- D-stage forwarding, per operand r:
  - Candidates: E, then M, then W, in priority order.
  - A stage qualifies when r≠0, A3==r and Tnew==0.
  - The first qualifying stage is selected; if none qualify, the select is RF.
- E-stage forwarding: same rule with candidates M then W.
- M-stage forwarding: same rule with candidate W only.
- Register 0 never forwards.
- MDU counter (cnt, width ≥ clog2(DIV_CYCLES+1)):
  - At an edge with md_start_E=1: cnt ← (md_type_E ? DIV_CYCLES : MULT_CYCLES).
  - Otherwise, if cnt≠0: cnt ← cnt−1.
- md_busy = (cnt≠0). md_done = (cnt==1).
- md_start_E while busy restarts the counter with the new length. The stall rule prevents this in normal operation.
- stall_cnt increments at every edge where stall=1 and saturates at 32'hFFFF_FFFF.
- Reset (reset==0 at an edge): cnt←0 and stall_cnt←0. Consequently md_busy=0 and md_done=0, and the combinational outputs reflect only the current inputs.
- Reset mid-operation aborts the MDU operation with no md_done pulse.

## Timing
- stall and all fwd_* are same-cycle combinational, with no latency.
- md_start_E high in cycle k:
  - md_busy is high in cycles k+1 … k+N, where N is the selected cycle count.
  - md_done is high in cycle k+N only.
  - md_busy is low in cycle k+N+1.
- In cycle k, md_busy is still at its previous value. stall still asserts for an md_D instruction via the md_start_E term.
- N=1: md_busy and md_done are both high in cycle k+1 only.
- stall_cnt reflects stalled cycles up to the previous edge (registered, 1-cycle lag).
- After reset deasserts, every output equals its reset-derived value until the first edge.

## Test plan
- lw $8 in E (A3_E=8, Tnew_E=2); D reads rs=8 with Tuse_rs_D=1 -> stall=1. Next cycle, lw in M (Tnew_M=1) -> stall=0, fwd_rs_D=0. Following cycle, lw in W (Tnew_W=0) -> fwd_rs_D=1.
- A3_E=A3_M=9, both Tnew=0, rs_D=9 -> fwd_rs_D=3 (E wins). With A3_E=0 instead -> fwd_rs_D=2. With rs_D=0 and all stages writing 0 -> fwd_rs_D=0, stall=0.
- md_start_E=1, md_type_E=0 at cycle 10 -> md_busy high in cycles 11–15, md_done high in cycle 15 only. md_D=1 during 10–15 -> stall=1; in cycle 16 -> stall=0.
- div start followed by reset==0 at cycle 4 of the busy period -> md_busy=0 next cycle, md_done never pulses, stall_cnt=0.
- stall held high for 3 consecutive cycles from reset -> stall_cnt reads 3 after the 3rd edge. Force the count to 32'hFFFF_FFFF with stall=1 -> it stays at 32'hFFFF_FFFF.
- rt_E=5 with A3_M=5, Tnew_M=0 and A3_W=5 -> fwd_rt_E=2. rt_M=5 with A3_W=5, Tnew_W=0 -> fwd_rt_M=1.
